// File: rtl/serial_parity_checker_if.sv
// Signal bundle between a serial bit source (master) and the parity checker (slave).
interface serial_parity_checker_if #(
    parameter int DATA_BITS = 8
);
    logic                 start;
    logic                 abort;
    logic                 bit_valid;
    logic                 serial_in;
    logic                 busy;
    logic                 running_parity;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_valid;
    logic                 parity_err;

    modport master (
        output start, abort, bit_valid, serial_in,
        input  busy, running_parity, data_out, frame_valid, parity_err
    );

    modport slave (
        input  start, abort, bit_valid, serial_in,
        output busy, running_parity, data_out, frame_valid, parity_err
    );
endinterface

// File: rtl/serial_parity_checker.sv
// Deserialises a DATA_BITS frame LSB first, accumulates its XOR parity and checks it
// against the trailing parity bit, reporting the word with a one-cycle frame_valid strobe.
module serial_parity_checker #(
    parameter int DATA_BITS  = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input logic                    clk,
    input logic                    rst,
    serial_parity_checker_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_BITS) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 acc_q, acc_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dataOut_q, dataOut_d;
    logic                 frameValid_q, frameValid_d;
    logic                 parityErr_q, parityErr_d;
    logic                 busy_q, busy_d;

    // Abort wins over bit_valid; start and abort together in IDLE leave the FSM idle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        dataOut_d    = dataOut_q;
        frameValid_d = 1'b0;
        parityErr_d  = parityErr_q;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    shift_d = '0;
                end
            end
            DATA: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end else if (bus.bit_valid) begin
                    for (int i = 0; i < DATA_BITS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shift_d[i] = bus.serial_in;
                        end
                    end
                    acc_d = acc_q ^ bus.serial_in;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                end else if (bus.bit_valid) begin
                    dataOut_d    = shift_q;
                    parityErr_d  = (bus.serial_in != (acc_q ^ ODD_PARITY));
                    frameValid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            shift_q      <= '0;
            dataOut_q    <= '0;
            frameValid_q <= 1'b0;
            parityErr_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            dataOut_q    <= dataOut_d;
            frameValid_q <= frameValid_d;
            parityErr_q  <= parityErr_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.running_parity = acc_q;
    assign bus.data_out       = dataOut_q;
    assign bus.frame_valid    = frameValid_q;
    assign bus.parity_err     = parityErr_q;
endmodule

// File: tb/tb_serial_parity_checker.sv
// Drives an even-parity and an odd-parity checker with the same serial stream and
// compares both against a frame-level model every cycle, plus hand-computed checks.
module tb_serial_parity_checker;
    logic clk;
    logic rst;
    logic start, abort, bitValid, serialIn;
    bit   checkEn;
    int   nCompared;
    int   nMismatch;

    serial_parity_checker_if #(.DATA_BITS(8)) ifE ();
    serial_parity_checker_if #(.DATA_BITS(8)) ifO ();

    assign ifE.start     = start;
    assign ifE.abort     = abort;
    assign ifE.bit_valid = bitValid;
    assign ifE.serial_in = serialIn;
    assign ifO.start     = start;
    assign ifO.abort     = abort;
    assign ifO.bit_valid = bitValid;
    assign ifO.serial_in = serialIn;

    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dutEven (
        .clk(clk), .rst(rst), .bus(ifE)
    );
    serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dutOdd (
        .clk(clk), .rst(rst), .bus(ifO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] actBusy, actRp, actFv, actErr;
    logic [7:0] actData [2];
    assign actBusy    = {ifO.busy, ifE.busy};
    assign actRp      = {ifO.running_parity, ifE.running_parity};
    assign actFv      = {ifO.frame_valid, ifE.frame_valid};
    assign actErr     = {ifO.parity_err, ifE.parity_err};
    assign actData[0] = ifE.data_out;
    assign actData[1] = ifO.data_out;

    // Frame-level model: a frame is "open" from an accepted start until the parity bit
    // following the eighth accepted data bit, or an abort.
    bit         oddSense [2] = '{1'b0, 1'b1};
    bit         mOpen    [2] = '{1'b0, 1'b0};
    int         mCnt     [2] = '{0, 0};
    logic [7:0] mWord    [2] = '{8'h00, 8'h00};
    logic [7:0] mData    [2] = '{8'h00, 8'h00};
    bit         mErr     [2] = '{1'b0, 1'b0};
    bit         mFv      [2] = '{1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mOpen[k] = 1'b0; mCnt[k] = 0; mWord[k] = 8'h00;
                mData[k] = 8'h00; mErr[k] = 1'b0; mFv[k] = 1'b0;
            end else begin
                mFv[k] = 1'b0;
                if (!mOpen[k]) begin
                    if (start && !abort) begin
                        mOpen[k] = 1'b1; mCnt[k] = 0; mWord[k] = 8'h00;
                    end
                end else if (abort) begin
                    mOpen[k] = 1'b0; mCnt[k] = 0; mWord[k] = 8'h00;
                end else if (bitValid) begin
                    if (mCnt[k] < 8) begin
                        mWord[k][mCnt[k][2:0]] = serialIn;
                        mCnt[k] = mCnt[k] + 1;
                    end else begin
                        mData[k] = mWord[k];
                        mErr[k]  = (serialIn != ((^mWord[k]) ^ oddSense[k]));
                        mFv[k]   = 1'b1;
                        mOpen[k] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("dut%0d busy", k), 32'(actBusy[k]), 32'(mOpen[k]));
                checkOutput($sformatf("dut%0d running_parity", k), 32'(actRp[k]), 32'(^mWord[k]));
                checkOutput($sformatf("dut%0d data_out", k), 32'(actData[k]), 32'(mData[k]));
                checkOutput($sformatf("dut%0d frame_valid", k), 32'(actFv[k]), 32'(mFv[k]));
                checkOutput($sformatf("dut%0d parity_err", k), 32'(actErr[k]), 32'(mErr[k]));
            end
        end
    end

    // Inputs set here are sampled at the following rising edge.
    task automatic applyStimulus(input logic s, input logic a, input logic v, input logic d);
        @(posedge clk);
        #2;
        start = s; abort = a; bitValid = v; serialIn = d;
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, b[i]);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " busy"}, 32'(actBusy), 32'h0);
        checkOutput({tag, " running_parity"}, 32'(actRp), 32'h0);
        checkOutput({tag, " frame_valid"}, 32'(actFv), 32'h0);
        checkOutput({tag, " parity_err"}, 32'(actErr), 32'h0);
        checkOutput({tag, " data_out even"}, 32'(actData[0]), 32'h0);
        checkOutput({tag, " data_out odd"}, 32'(actData[1]), 32'h0);
    endtask

    initial begin
        nCompared = 0; nMismatch = 0; checkEn = 1'b0;
        start = 1'b0; abort = 1'b0; bitValid = 1'b0; serialIn = 1'b0;
        rst = 1'b0;
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 checkAllZero("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        checkEn = 1'b1;

        // Frame 0xA5 (even population) with correct even parity bit.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sendByte(8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t1 frame_valid", 32'(ifE.frame_valid), 32'h1);
        checkOutput("t1 data_out", 32'(ifE.data_out), 32'hA5);
        checkOutput("t1 parity_err", 32'(ifE.parity_err), 32'h0);
        checkOutput("t1 busy", 32'(ifE.busy), 32'h0);
        checkOutput("t1 odd parity_err", 32'(ifO.parity_err), 32'h1);

        // Same frame with a wrong parity bit; the error must persist while idle.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sendByte(8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t2 data_out", 32'(ifE.data_out), 32'hA5);
        checkOutput("t2 parity_err", 32'(ifE.parity_err), 32'h1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t2 parity_err held", 32'(ifE.parity_err), 32'h1);
        checkOutput("t2 frame_valid low", 32'(ifE.frame_valid), 32'h0);

        // Data 0x01, parity bit 0: correct for odd sense, wrong for even.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3 running_parity odd", 32'(ifO.running_parity), 32'h1);
        checkOutput("t3 running_parity even", 32'(ifE.running_parity), 32'h1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3 odd data_out", 32'(ifO.data_out), 32'h01);
        checkOutput("t3 odd parity_err", 32'(ifO.parity_err), 32'h0);
        checkOutput("t3 even parity_err", 32'(ifE.parity_err), 32'h1);

        // Three bits with stalls, then abort together with bit_valid.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t4 busy", 32'(ifE.busy), 32'h0);
        checkOutput("t4 frame_valid", 32'(ifE.frame_valid), 32'h0);
        checkOutput("t4 data_out kept", 32'(ifE.data_out), 32'h01);
        checkOutput("t4 running_parity", 32'(ifE.running_parity), 32'h0);

        // Start with bit_valid: that bit is dropped; restart in the strobe cycle.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        sendByte(8'h3C);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5 frame_valid", 32'(ifE.frame_valid), 32'h1);
        checkOutput("t5 data_out", 32'(ifE.data_out), 32'h3C);
        checkOutput("t5 parity_err", 32'(ifE.parity_err), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5 restart busy", 32'(ifE.busy), 32'h1);

        // Start during DATA must not restart the frame: bits 1,1,0,1,0,0,0,0 = 0x0B.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t6 frame_valid", 32'(ifE.frame_valid), 32'h1);
        checkOutput("t6 data_out", 32'(ifE.data_out), 32'h0B);
        checkOutput("t6 parity_err", 32'(ifE.parity_err), 32'h0);

        // Asynchronous reset between edges in the middle of a frame.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1 checkAllZero("t6 async reset");
        #3 rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sendByte(8'h81);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post-reset data_out", 32'(ifE.data_out), 32'h81);
        checkOutput("post-reset parity_err", 32'(ifE.parity_err), 32'h0);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkEn = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
